// File: rtl/arith_pkg.sv
// Shared arithmetic types and constants for the shift-add multiplier
// and its carry-lookahead adder.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_DATA_W = 8;
  localparam int MUL_STEPS  = 8;

endpackage

// File: rtl/carry_lookahead_adder_8b.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups
// chained through the group carry.
module carry_lookahead_adder_8b (
  input  logic [7:0] iA,
  input  logic [7:0] iB,
  input  logic       iCarryIn,
  output logic [7:0] oSum,
  output logic       oCarry
);

  logic [7:0] g;
  logic [7:0] p;
  logic [3:0] c_lo;
  logic [3:0] c_hi;

  function automatic logic [3:0] cla4(
    input logic [3:0] gg,
    input logic [3:0] pp,
    input logic       c0
  );
    logic [3:0] c;
    c[0] = gg[0] | (pp[0] & c0);
    c[1] = gg[1] | (pp[1] & gg[0])
         | (pp[1] & pp[0] & c0);
    c[2] = gg[2] | (pp[2] & gg[1])
         | (pp[2] & pp[1] & gg[0])
         | (pp[2] & pp[1] & pp[0] & c0);
    c[3] = gg[3] | (pp[3] & gg[2])
         | (pp[3] & pp[2] & gg[1])
         | (pp[3] & pp[2] & pp[1] & gg[0])
         | (pp[3] & pp[2] & pp[1] & pp[0] & c0);
    return c;
  endfunction

  assign g = iA & iB;
  assign p = iA ^ iB;

  assign c_lo = cla4(g[3:0], p[3:0], iCarryIn);
  assign c_hi = cla4(g[7:4], p[7:4], c_lo[3]);

  assign oSum   = p ^ {c_hi[2:0], c_lo, iCarryIn};
  assign oCarry = c_hi[3];

endmodule

// File: rtl/shift_add_multiplier_8b.sv
// Sequential 8x8 unsigned shift-add multiplier with valid/ready on both sides.
// Optional early termination on exhausted multiplier bits: MUL_EARLY_TERM_EN.
module shift_add_multiplier_8b
  import arith_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iValid,
  output logic                oReady,
  input  logic [DATA_W-1:0]   iMultiplicand,
  input  logic [DATA_W-1:0]   iMultiplier,
  output logic                oValid,
  input  logic                iReady,
  output logic [2*DATA_W-1:0] oProduct,
  output logic                oBusy
);

  if (DATA_W != MUL_DATA_W || CNT_W != 3) begin : g_bad_width
    $error("shift_add_multiplier_8b supports DATA_W=8, CNT_W=3 only");
  end

  mul_state_e state_q, state_d;

  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mq_q, mq_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;

  logic [DATA_W-1:0]   add_b;
  logic [DATA_W-1:0]   sum;
  logic                carry;
  logic [2*DATA_W-1:0] shifted;
  logic [2*DATA_W-1:0] prod_val;
  logic [CNT_W:0]      step_n;
  logic                last_step;

  assign add_b = mq_q[0] ? mcand_q : '0;

  carry_lookahead_adder_8b u_adder (
    .iA       (acc_q),
    .iB       (add_b),
    .iCarryIn (1'b0),
    .oSum     (sum),
    .oCarry   (carry)
  );

  // Carry-out becomes the shift-in bit, so no step drops information.
  assign shifted = {carry, sum, mq_q[DATA_W-1:1]};
  assign step_n  = {1'b0, cnt_q} + (CNT_W+1)'(1);

`ifdef MUL_EARLY_TERM_EN
  logic [DATA_W-1:0] pend_mask;

  // Low DATA_W-step_n bits of the shifted mq are still unprocessed.
  assign pend_mask = {DATA_W{1'b1}} >> step_n;
  assign last_step = (step_n == (CNT_W+1)'(MUL_STEPS))
                   || ((shifted[DATA_W-1:0] & pend_mask) == '0);
  assign prod_val  = shifted
                   >> ((CNT_W+1)'(DATA_W) - step_n);
`else
  assign last_step = (step_n == (CNT_W+1)'(MUL_STEPS));
  assign prod_val  = shifted;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          mcand_d = iMultiplicand;
          mq_d    = iMultiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = shifted[2*DATA_W-1:DATA_W];
        mq_d  = shifted[DATA_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          prod_d  = prod_val;
          state_d = DONE;
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign oReady   = (state_q == IDLE);
  assign oBusy    = (state_q == RUN);
  assign oValid   = (state_q == DONE);
  assign oProduct = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier_8b.sv
// Self-checking bench for shift_add_multiplier_8b: directed cases plus
// random operands against a plain-arithmetic product/latency model.
module tb_shift_add_multiplier_8b;

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [7:0]  iMultiplicand;
  logic [7:0]  iMultiplier;
  logic        oValid;
  logic        iReady;
  logic [15:0] oProduct;
  logic        oBusy;

  int errors;
  int checks;
  int accepts;

  shift_add_multiplier_8b dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iValid        (iValid),
    .oReady        (oReady),
    .iMultiplicand (iMultiplicand),
    .iMultiplier   (iMultiplier),
    .oValid        (oValid),
    .iReady        (iReady),
    .oProduct      (oProduct),
    .oBusy         (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    if (!iRst && iValid && oReady) accepts++;
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the operand-present cycle to oValid rising.
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_EARLY_TERM_EN
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) return i + 2;
    end
    return 2;
`else
    return 9;
`endif
  endfunction

  task automatic run_op(input logic [7:0] a,
                        input logic [7:0] b,
                        input int hold,
                        input string tag);
    int lat;
    logic [15:0] want;
    want = 16'(a) * 16'(b);
    chk({tag, "_ready"}, 32'(oReady), 32'd1);
    iMultiplicand = a;
    iMultiplier   = b;
    iValid        = 1'b1;
    iReady        = (hold == 0);
    tick();
    iValid = 1'b0;
    iMultiplicand = $urandom;
    iMultiplier   = $urandom;
    lat = 1;
    while (!oValid && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(b)));
    chk({tag, "_prod"}, 32'(oProduct), 32'(want));
    chk({tag, "_rdy_done"}, 32'(oReady), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_v"}, 32'(oValid), 32'd1);
      chk({tag, "_hold_p"}, 32'(oProduct), 32'(want));
      chk({tag, "_hold_r"}, 32'(oReady), 32'd0);
    end
    iReady = 1'b1;
    tick();
    chk({tag, "_v_drop"}, 32'(oValid), 32'd0);
    chk({tag, "_idle"}, 32'(oReady), 32'd1);
  endtask

  initial begin
    int lat;
    int acc0;
    logic [7:0] ra;
    logic [7:0] rb;
    errors        = 0;
    checks        = 0;
    accepts       = 0;
    iRst          = 1'b1;
    iValid        = 1'b0;
    iReady        = 1'b0;
    iMultiplicand = '0;
    iMultiplier   = '0;
    #3;
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_prod", 32'(oProduct), 32'd0);
    tick();
    iRst = 1'b0;
    tick();

    run_op(8'hFF, 8'hFF, 0, "ff_ff");
    run_op(8'h0D, 8'h0B, 5, "d_b_hold");
    run_op(8'h00, 8'hA5, 0, "zero_a");
    run_op(8'h5A, 8'h00, 0, "zero_b");
    run_op(8'h12, 8'h01, 0, "b_one");
    run_op(8'h01, 8'h80, 1, "b_msb");

    // Back-to-back with iValid held high: each pair accepted once.
    acc0          = accepts;
    iReady        = 1'b1;
    iMultiplicand = 8'h80;
    iMultiplier   = 8'h02;
    iValid        = 1'b1;
    tick();
    chk("b2b_busy", 32'(oBusy), 32'd1);
    iMultiplicand = 8'h03;
    iMultiplier   = 8'h05;
    lat = 1;
    while (!oValid && lat < 30) begin
      tick();
      lat++;
    end
    chk("b2b_lat1", 32'(lat), 32'(exp_lat(8'h02)));
    chk("b2b_p1", 32'(oProduct), 32'h0100);
    tick();
    chk("b2b_gap_v", 32'(oValid), 32'd0);
    chk("b2b_gap_r", 32'(oReady), 32'd1);
    tick();
    iValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 30) begin
      tick();
      lat++;
    end
    chk("b2b_lat2", 32'(lat), 32'(exp_lat(8'h05)));
    chk("b2b_p2", 32'(oProduct), 32'h000F);
    tick();
    tick();
    chk("b2b_accepts", 32'(accepts - acc0), 32'd2);
    chk("b2b_idle_busy", 32'(oBusy), 32'd0);

    // Reset in the middle of a run abandons it.
    iMultiplicand = 8'h12;
    iMultiplier   = 8'h34;
    iValid        = 1'b1;
    tick();
    iValid = 1'b0;
    tick();
    tick();
    tick();
    iRst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(oBusy), 32'd0);
    chk("mid_rst_ready", 32'(oReady), 32'd1);
    chk("mid_rst_prod", 32'(oProduct), 32'd0);
    tick();
    iRst = 1'b0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (oValid) lat++;
    end
    chk("mid_rst_novalid", 32'(lat), 32'd0);
    run_op(8'h02, 8'h03, 0, "after_rst");

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 6 == 0) rb = 8'(1 << $urandom_range(0, 7));
      run_op(ra, rb, int'($urandom_range(0, 2)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
